// File: rtl/upg_dump_tx.sv
// upg_dump_tx: serial memory dump engine.
// Reads word_cnt_i 32-bit words starting at base_adr_i from a synchronous
// RAM and sends them on upg_tx_o as 8N1 frames, least-significant byte first.
// Optional feature macro: UPG_DUMP_CKSUM_EN appends one frame carrying the
// XOR of every data byte sent in the dump.
module upg_dump_tx #(
    parameter int unsigned BAUD_DIV = 87,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic              upg_clk_i,
    input  logic              nrst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_adr_i,
    input  logic [ADDR_W:0]   word_cnt_i,
    output logic [ADDR_W-1:0] mem_adr_o,
    input  logic [31:0]       mem_dat_i,
    output logic              upg_tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [15:0]       BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t              state_q;
    logic [15:0]         baud_q;
    logic [3:0]          bit_q;
    logic [1:0]          byte_q;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [31:0]         shift_q;
    logic                tx_q;
    logic                busy_q;
    logic                done_q;
    // Holds FIN for one extra cycle on an empty dump so done lands two edges after start.
    logic                zero_q;
`ifdef UPG_DUMP_CKSUM_EN
    logic [7:0]          xor_q;
    logic                cks_q;
`endif

    logic [7:0]          byte_s;
    logic                tx_d;
    logic                bit_end_s;
    logic                cks_frame_s;

    // Line level for the current frame position and end-of-bit decode.
    always_comb begin
        byte_s    = shift_q[7:0];
        bit_end_s = (baud_q == BAUD_LAST);
        tx_d      = 1'b1;
        case (bit_q)
            4'd0:    tx_d = 1'b0;
            4'd9:    tx_d = 1'b1;
            default: tx_d = byte_s[3'(bit_q - 4'd1)];
        endcase
`ifdef UPG_DUMP_CKSUM_EN
        cks_frame_s = cks_q;
`else
        cks_frame_s = 1'b0;
`endif
    end

    // Dump sequencer: fetch, load, serialise, advance, finish.
    always_ff @(posedge upg_clk_i or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            cnt_q   <= CNT_ZERO;
            adr_q   <= ADR_ZERO;
            shift_q <= 32'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
`ifdef UPG_DUMP_CKSUM_EN
            xor_q   <= 8'h00;
            cks_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (start_i) begin
                        cnt_q  <= word_cnt_i;
                        baud_q <= 16'd0;
                        bit_q  <= 4'd0;
                        byte_q <= 2'd0;
`ifdef UPG_DUMP_CKSUM_EN
                        xor_q  <= 8'h00;
                        cks_q  <= 1'b0;
`endif
                        if (word_cnt_i != CNT_ZERO) begin
                            adr_q   <= base_adr_i;
                            busy_q  <= 1'b1;
                            state_q <= ST_READ;
                        end else begin
                            zero_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_READ: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_q    <= 1'b1;
                    shift_q <= mem_dat_i;
                    baud_q  <= 16'd0;
                    bit_q   <= 4'd0;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    tx_q <= tx_d;
                    if (bit_end_s) begin
                        baud_q <= 16'd0;
                        if (bit_q == 4'd9) begin
                            bit_q <= 4'd0;
                            if (cks_frame_s) begin
                                state_q <= ST_FIN;
                            end else begin
`ifdef UPG_DUMP_CKSUM_EN
                                xor_q <= xor_q ^ byte_s;
`endif
                                shift_q <= {8'h00, shift_q[31:8]};
                                byte_q  <= byte_q + 2'd1;
                                if (byte_q == 2'd3) begin
                                    cnt_q <= cnt_q - CNT_ONE;
                                    if (cnt_q == CNT_ONE) begin
`ifdef UPG_DUMP_CKSUM_EN
                                        // Trailer frame reuses the shifter, starting right after this stop bit.
                                        cks_q   <= 1'b1;
                                        shift_q <= {24'h000000, xor_q ^ byte_s};
`else
                                        state_q <= ST_FIN;
`endif
                                    end else begin
                                        adr_q   <= adr_q + ADR_ONE;
                                        state_q <= ST_READ;
                                    end
                                end
                            end
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                ST_FIN: begin
                    tx_q <= 1'b1;
                    if (zero_q) begin
                        zero_q <= 1'b0;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`ifdef UPG_DUMP_CKSUM_EN
                        cks_q   <= 1'b0;
`endif
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_adr_o = adr_q;
    assign upg_tx_o  = tx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_upg_dump_tx.sv
// Self-checking bench for upg_dump_tx with BAUD_DIV=4, ADDR_W=14.
module tb_upg_dump_tx;

    localparam int B = 4;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [13:0] base_adr;
    logic [14:0] word_cnt;
    logic [13:0] mem_adr;
    logic [31:0] mem_dat;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:16383];

    int n_checks = 0;
    int n_errors = 0;

    upg_dump_tx #(.BAUD_DIV(B), .ADDR_W(14)) dut (
        .upg_clk_i  (clk),
        .nrst       (nrst),
        .start_i    (start),
        .base_adr_i (base_adr),
        .word_cnt_i (word_cnt),
        .mem_adr_o  (mem_adr),
        .mem_dat_i  (mem_dat),
        .upg_tx_o   (tx),
        .busy_o     (busy),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: data valid one cycle after the address.
    always_ff @(posedge clk) mem_dat <= mem[mem_adr];

    typedef struct {
        logic [13:0] base;
        logic [14:0] cnt;
        logic [95:0] eb;   // expected byte j at [8j+:8]
        logic [7:0]  ck;   // expected trailer byte
        bit          inject;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int frame_pos(input int j, input int nb, input int nw);
        return 3 + j * 10 * B + 2 * ((j < nb) ? (j / 4) : (nw - 1));
    endfunction

    function automatic logic exp_tx(input int k, input int nf, input int nb, input int nw,
                                    input logic [95:0] eb, input logic [7:0] ck);
        logic       r;
        logic [7:0] byt;
        int         p;
        int         bi;
        r = 1'b1;
        for (int j = 0; j < nf; j++) begin
            p = frame_pos(j, nb, nw);
            if (k >= p && k < p + 10 * B) begin
                bi  = (k - p) / B;
                byt = (j < nb) ? eb[8*j +: 8] : ck;
                if (bi == 0)      r = 1'b0;
                else if (bi == 9) r = 1'b1;
                else              r = byt[bi-1];
            end
        end
        return r;
    endfunction

    task automatic run_dump(input logic [13:0] base, input logic [14:0] cnt,
                            input logic [95:0] eb, input logic [7:0] ck, input bit inject);
        int          nw;
        int          nb;
        int          nf;
        int          k_done;
        int          p;
        logic        txs [0:2047];
        logic [7:0]  dec;
        logic [13:0] ea;
        nw = int'(cnt);
        nb = 4 * nw;
        nf = nb;
`ifdef UPG_DUMP_CKSUM_EN
        nf = nb + 1;
`endif
        k_done = frame_pos(nf - 1, nb, nw) + 10 * B;
        @(negedge clk);
        start    = 1'b1;
        base_adr = base;
        word_cnt = cnt;
        for (int k = 0; k <= k_done + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) start = 1'b0;
            if (inject && k == 50) begin
                start    = 1'b1;
                base_adr = 14'h0100;
                word_cnt = 15'd5;
            end
            if (inject && k == 51) start = 1'b0;
            txs[k] = tx;
            chk("tx_wave", 32'(tx), 32'(exp_tx(k, nf, nb, nw, eb, ck)));
            chk("done", 32'(done), 32'(k == k_done));
            chk("busy", 32'(busy), 32'(k < k_done));
            for (int w = 0; w < nw; w++) begin
                if (k == frame_pos(4 * w, nb, nw) - 3) begin
                    ea = base + 14'(w);
                    chk("rd_adr", 32'(mem_adr), 32'(ea));
                end
            end
        end
        // Mid-bit decode of every frame, independent of the per-cycle comparison.
        for (int j = 0; j < nf; j++) begin
            p = frame_pos(j, nb, nw);
            for (int i = 0; i < 8; i++) dec[i] = txs[p + (i + 1) * B + B / 2];
            chk("start_bit", 32'(txs[p + B / 2]), 32'd0);
            chk("stop_bit", 32'(txs[p + 9 * B + B / 2]), 32'd1);
            chk("rx_byte", 32'(dec), 32'((j < nb) ? eb[8*j +: 8] : ck));
        end
    endtask

    initial begin
        nrst     = 1'b0;
        start    = 1'b0;
        base_adr = 14'h0000;
        word_cnt = 15'd0;
        for (int a = 0; a < 16384; a++) mem[a] = 32'h00000000;
        mem[14'h0010] = 32'h12345678;
        mem[14'h3FFE] = 32'hA1B2C3D4;
        mem[14'h3FFF] = 32'h0F1E2D3C;
        mem[14'h0000] = 32'hCAFEBABE;
        mem[14'h0020] = 32'h000000FF;
        mem[14'h0021] = 32'h0000FF01;

        // bytes in line order, byte j at [8j+:8]; trailer is XOR of all bytes
        vecs[0] = '{14'h0010, 15'd1, {64'h0, 8'h12, 8'h34, 8'h56, 8'h78}, 8'h08, 1'b0};
        vecs[1] = '{14'h3FFE, 15'd3, {8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h0F, 8'h1E, 8'h2D, 8'h3C,
                                      8'hA1, 8'hB2, 8'hC3, 8'hD4}, 8'h34, 1'b1};
        vecs[2] = '{14'h0020, 15'd2, {32'h0, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF},
                    8'h01, 1'b0};

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_adr", 32'(mem_adr), 32'd0);
        end

        // Table-driven dumps
        for (int v = 0; v < 3; v++) begin
            run_dump(vecs[v].base, vecs[v].cnt, vecs[v].eb, vecs[v].ck, vecs[v].inject);
            repeat (5) @(posedge clk);
        end

        // Empty dump: done two edges after start, nothing else moves
        @(negedge clk);
        start    = 1'b1;
        base_adr = 14'h0555;
        word_cnt = 15'd0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) start = 1'b0;
            chk("zero_done", 32'(done), 32'(k == 2));
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_tx", 32'(tx), 32'd1);
            chk("zero_adr", 32'(mem_adr), 32'h0021);
        end

        // Reset during the start bit of the second byte
        @(negedge clk);
        start    = 1'b1;
        base_adr = 14'h0010;
        word_cnt = 15'd1;
        for (int k = 0; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) start = 1'b0;
        end
        chk("pre_rst_tx", 32'(tx), 32'd0);
        nrst = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_adr", 32'(mem_adr), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_tx", 32'(tx), 32'd1);
        end
        run_dump(14'h3FFE, 15'd1, {64'h0, 8'hA1, 8'hB2, 8'hC3, 8'hD4}, 8'h04, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/upg_dump_tx.md
# upg_dump_tx

Serial memory dump engine: the transmit-direction counterpart of the UART programmer. On a start pulse it reads a contiguous range of 32-bit words from the data-memory read port and sends them out on the UART TX pin as 8N1 frames, little-endian byte order. It sits beside the programmer on the UART pins and shares the programmer's clock domain. Its purpose is to let the host read back memory contents, for example to verify a download.

## Interface
- BAUD_DIV, default 87: clock cycles per bit (10 MHz / 115200); legal range 2..65535.
- ADDR_W, default 14: word-address width; matches the memory word address.
- upg_clk_i  in  1  UART-side clock; all logic is on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start request; sampled only in IDLE.
- base_adr_i  in  ADDR_W  first word address; sampled together with start_i.
- word_cnt_i  in  ADDR_W+1  number of words to send; sampled together with start_i.
- mem_adr_o  out  ADDR_W  memory word address.
- mem_dat_i  in  32  memory read data; valid one cycle after mem_adr_o is presented (synchronous RAM).
- upg_tx_o  out  1  serial TX line; idles high.
- busy_o  out  1  high from the cycle after start is accepted until done_o is asserted.
- done_o  out  1  one-cycle pulse when the dump completes.

## Operation
- States and transitions:
  - IDLE → READ when start_i=1 and word_cnt_i≠0.
  - IDLE → FIN when start_i=1 and word_cnt_i=0.
  - READ → LOAD → SEND.
  - SEND → SEND for each further byte of the word.
  - SEND → READ for the next word.
  - SEND → FIN after the last word.
  - FIN → IDLE.
- READ: drive mem_adr_o with the current address.
- LOAD: capture mem_dat_i into a 32-bit shift register.
- SEND: transmit bytes [7:0], [15:8], [23:16], [31:24] in that order. Each byte is one frame: start bit 0, data bits LSB first, stop bit 1.
- After each word, the address increments modulo 2^ADDR_W (0x3FFF wraps to 0x0000) and the remaining count decrements.
- FIN: done_o=1 for one cycle, busy_o drops, and the state returns to IDLE.
- start_i outside IDLE is ignored; it is not queued.
- Counters:
  - baud counter: 16 bits, counts 0..BAUD_DIV-1.
  - bit index: 0..9 within a frame.
  - byte index: 0..3 within a word.
  - remaining-word counter: ADDR_W+1 bits.
- Reset values: upg_tx_o=1, busy_o=0, done_o=0, mem_adr_o=0; state=IDLE, all counters 0.
- Asserting nrst mid-frame forces upg_tx_o high immediately and abandons the dump. No done_o pulse is produced.

## Timing
- Start accepted on edge N:
  - mem_adr_o = base_adr_i from edge N+1 (READ).
  - Data captured at edge N+2 (LOAD).
  - upg_tx_o falls at edge N+3.
- Each bit is held for exactly BAUD_DIV cycles. One frame is 10×BAUD_DIV cycles.
- Bytes within a word are back-to-back: the next start bit directly follows the stop bit.
- At a word boundary, READ and LOAD add 2 cycles with the line high, so that stop bit lasts BAUD_DIV+2 cycles.
- Total dump time for W words: 3 + W×(40×BAUD_DIV+2) − 2 cycles from start acceptance to the end of the final stop bit.
- done_o pulses on the cycle after the final stop bit ends. The checksum frame, when enabled, is sent before done_o.
- word_cnt_i=0: done_o is asserted at edge N+2. No TX activity and no memory read occur.
- mem_adr_o holds its last value outside READ.

## Configuration
- UPG_DUMP_CKSUM_EN defined:
  - After the last data byte, one extra 8N1 frame is sent carrying the XOR of every data byte transmitted in this dump.
  - The running XOR resets to 0x00 at start acceptance.
  - The extra frame begins immediately after the last stop bit, with no gap.
  - The word_cnt_i=0 case sends no checksum frame.
- UPG_DUMP_CKSUM_EN undefined: no trailer frame, and no XOR register is implemented.

## Test plan
- Reset, then idle 100 cycles → upg_tx_o=1, busy_o=0, done_o=0, mem_adr_o=0 throughout.
- BAUD_DIV=4, base=0x0010, cnt=1, mem[0x10]=0x12345678 → line decodes bytes 0x78,0x56,0x34,0x12; tx falls 3 cycles after start; done_o pulses once.
- cnt=3 from base=0x3FFE → reads addresses 0x3FFE, 0x3FFF, 0x0000 in that order; word-boundary stop bits last 6 cycles (BAUD_DIV+2).
- cnt=0 → done_o at N+2, no tx transition, busy_o stays 0; a start pulse during an active dump is ignored and the byte stream is unchanged.
- nrst pulsed low mid-frame on the 2nd byte → upg_tx_o=1 at once, no done_o; a new start afterwards dumps correctly from its own base.
- With UPG_DUMP_CKSUM_EN, words 0x000000FF and 0x0000FF01 → trailer byte 0x01; without the macro, the stream ends after 8 bytes.
